// File: rtl/uart_fifo_bridge_if.sv
// Memory-mapped bus bundle between the SoC data-bus decoder and uart_fifo_bridge.
// The master modport is the decoder/core side and the slave modport is the bridge side.
interface uart_fifo_bridge_if;
    logic        sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output sel, mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  sel, mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: buffered, memory-mapped UART front end with TX/RX FIFOs,
// a TX drain state machine, sticky error flags and an optional interrupt.
// Build option: define UART_FIFO_IRQ_EN to enable irq_o and CTRL[4:2];
// without it, irq_o is tied low and CTRL[4:2] read as zero.
//
// state      | meaning
// B_IDLE     | bus idle, accepts a request and applies its side effect
// B_RESP     | mem_ready high for one cycle with registered read data
// T_IDLE     | TX idle, pops the FIFO head when enabled and uart_tx is free
// T_WAIT_HI  | byte loaded, waiting for uart_tx_busy to rise
// T_WAIT_LO  | byte shifting, waiting for uart_tx_busy to fall
module uart_fifo_bridge #(
    parameter int          TX_DEPTH   = 8,
    parameter int          RX_DEPTH   = 8,
    parameter logic [31:0] CTRL_RESET = 32'h0000_0003
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_fifo_bridge_if.slave   bus,
    output logic                uart_tx_en_o,
    input  logic                uart_tx_busy_i,
    output logic [7:0]          uart_tx_data_o,
    output logic                uart_rx_en_o,
    input  logic                uart_rx_break_i,
    input  logic                uart_rx_valid_i,
    input  logic [7:0]          uart_rx_data_i,
    output logic                irq_o
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_ONE = 1;
    localparam logic [RAW:0] RX_ONE = 1;

    typedef enum logic {B_IDLE, B_RESP} b_state_e;
    typedef enum logic [1:0] {T_IDLE, T_WAIT_HI, T_WAIT_LO} t_state_e;

    b_state_e     b_state_q, b_state_d;
    t_state_e     t_state_q, t_state_d;
    logic [TAW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [RAW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [7:0]   tx_mem [TX_DEPTH];
    logic [7:0]   rx_mem [RX_DEPTH];
    logic [4:0]   ctrl_q, ctrl_d;
    logic         tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, rx_brk_q, rx_brk_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         tx_en_q, tx_en_d;
    logic [7:0]   tx_data_q, tx_data_d;

    logic         accept, wr_en, rd_en, ctrl_wr, stat_wr, tx_flush, rx_flush;
    logic [1:0]   reg_sel;
    logic         tx_empty, tx_full, rx_empty, rx_full, tx_active;
    logic [TAW:0] tx_level;
    logic [RAW:0] rx_level;
    logic         tx_push_req, tx_push, tx_pop, tx_ovf_set;
    logic         rx_push, rx_pop, rx_ovr_set;
    logic [31:0]  status;

    assign reg_sel  = bus.mem_addr[3:2];
    assign accept   = (b_state_q == B_IDLE) && bus.sel && (bus.mem_we || bus.mem_re);
    assign wr_en    = accept && bus.mem_we;
    assign rd_en    = accept && !bus.mem_we;
    assign ctrl_wr  = wr_en && (reg_sel == 2'd2);
    assign stat_wr  = wr_en && (reg_sel == 2'd1);
    assign tx_flush = ctrl_wr && bus.mem_wdata[8];
    assign rx_flush = ctrl_wr && bus.mem_wdata[9];

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[TAW] != tx_rd_q[TAW]) && (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[RAW] != rx_rd_q[RAW]) && (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);
    assign tx_level = tx_wr_q - tx_rd_q;
    assign rx_level = rx_wr_q - rx_rd_q;

    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign tx_pop      = (t_state_q == T_IDLE) && ctrl_q[0] && !tx_empty && !uart_tx_busy_i;
    assign tx_push_req = wr_en && (reg_sel == 2'd0);
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_ovf_set  = tx_push_req && tx_full && !tx_pop;
    assign rx_pop      = rd_en && (reg_sel == 2'd0) && !rx_empty;
    assign rx_push     = uart_rx_valid_i && !rx_flush && (!rx_full || rx_pop);
    assign rx_ovr_set  = uart_rx_valid_i && !rx_flush && rx_full && !rx_pop;

    assign tx_active = (t_state_q != T_IDLE) || uart_tx_busy_i;
    assign status    = {8'h00, 8'(rx_level), 8'(tx_level), tx_active, rx_brk_q, rx_ovr_q,
                        tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};

    // FIFO storage; no reset needed since occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q[TAW-1:0]] <= bus.mem_wdata[7:0];
        if (rx_push) rx_mem[rx_wr_q[RAW-1:0]] <= uart_rx_data_i;
    end

    // Pointer next-state; a flush empties the FIFO and wins over a same-cycle push.
    always_comb begin
        tx_wr_d = tx_wr_q;
        tx_rd_d = tx_rd_q;
        rx_wr_d = rx_wr_q;
        rx_rd_d = rx_rd_q;
        if (tx_flush) begin
            tx_rd_d = tx_wr_q;
        end else begin
            if (tx_push) tx_wr_d = tx_wr_q + TX_ONE;
            if (tx_pop)  tx_rd_d = tx_rd_q + TX_ONE;
        end
        if (rx_flush) begin
            rx_rd_d = rx_wr_q;
        end else begin
            if (rx_push) rx_wr_d = rx_wr_q + RX_ONE;
            if (rx_pop)  rx_rd_d = rx_rd_q + RX_ONE;
        end
    end

    // Register file next-state: CTRL, sticky flags (hardware set beats W1C), read data.
    always_comb begin
        ctrl_d   = ctrl_q;
        tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~(stat_wr & bus.mem_wdata[4]));
        rx_ovr_d = rx_ovr_set | (rx_ovr_q & ~(stat_wr & bus.mem_wdata[5]));
        rx_brk_d = uart_rx_break_i | (rx_brk_q & ~(stat_wr & bus.mem_wdata[6]));
        rdata_d  = 32'h0;
        if (ctrl_wr) begin
`ifdef UART_FIFO_IRQ_EN
            ctrl_d = bus.mem_wdata[4:0];
`else
            ctrl_d = {3'b000, bus.mem_wdata[1:0]};
`endif
        end
        if (rd_en) begin
            case (reg_sel)
                2'd0:    rdata_d = rx_empty ? 32'h0 : {23'h0, 1'b1, rx_mem[rx_rd_q[RAW-1:0]]};
                2'd1:    rdata_d = status;
                2'd2:    rdata_d = {27'h0, ctrl_q};
                default: rdata_d = 32'h0;
            endcase
        end
    end

    // Bus FSM next-state: one response cycle per accepted request.
    always_comb begin
        b_state_d = B_IDLE;
        if (b_state_q == B_IDLE && accept) b_state_d = B_RESP;
    end

    // TX drain FSM next-state and load strobe.
    always_comb begin
        t_state_d = t_state_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        case (t_state_q)
            T_IDLE: begin
                if (tx_pop) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = tx_mem[tx_rd_q[TAW-1:0]];
                    t_state_d = T_WAIT_HI;
                end
            end
            T_WAIT_HI: if (uart_tx_busy_i)  t_state_d = T_WAIT_LO;
            T_WAIT_LO: if (!uart_tx_busy_i) t_state_d = T_IDLE;
            default:   t_state_d = T_IDLE;
        endcase
    end

    // State and register updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_state_q <= B_IDLE;
            t_state_q <= T_IDLE;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
`ifdef UART_FIFO_IRQ_EN
            ctrl_q    <= CTRL_RESET[4:0];
`else
            ctrl_q    <= {3'b000, CTRL_RESET[1:0]};
`endif
            tx_ovf_q  <= 1'b0;
            rx_ovr_q  <= 1'b0;
            rx_brk_q  <= 1'b0;
            rdata_q   <= 32'h0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            b_state_q <= b_state_d;
            t_state_q <= t_state_d;
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
            ctrl_q    <= ctrl_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_ovr_q  <= rx_ovr_d;
            rx_brk_q  <= rx_brk_d;
            rdata_q   <= rdata_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign bus.mem_ready  = (b_state_q == B_RESP);
    assign bus.mem_rdata  = rdata_q;
    assign uart_tx_en_o   = tx_en_q;
    assign uart_tx_data_o = tx_data_q;
    assign uart_rx_en_o   = ctrl_q[1];

`ifdef UART_FIFO_IRQ_EN
    logic irq_q, irq_d;
    logic unused_bits;
    assign unused_bits = ^{bus.mem_addr[31:4], bus.mem_addr[1:0], bus.mem_wdata[31:10]};

    // Interrupt cause, registered so irq_o lags its cause by one cycle.
    always_comb begin
        irq_d = (ctrl_q[2] & !rx_empty)
              | (ctrl_q[3] & tx_empty & (t_state_q == T_IDLE))
              | (ctrl_q[4] & (tx_ovf_q | rx_ovr_q | rx_brk_q));
    end

    // Interrupt register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq_o = irq_q;
`else
    logic unused_bits;
    assign unused_bits = ^{bus.mem_addr[31:4], bus.mem_addr[1:0], bus.mem_wdata[31:10],
                           bus.mem_wdata[3:2]};
    assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge with a uart_tx model that stays busy
// for 10 cycles after each load strobe.
module tb_uart_fifo_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef UART_FIFO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    uart_fifo_bridge_if bus_if ();

    logic       tx_en, tx_busy, rx_en, rx_break, rx_valid, irq;
    logic [7:0] tx_data, rx_data;
    int         busy_cnt;
    logic [7:0] tx_log [$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [31:0] r;

    uart_fifo_bridge #(.TX_DEPTH(8), .RX_DEPTH(8), .CTRL_RESET(32'h3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus_if),
        .uart_tx_en_o   (tx_en),
        .uart_tx_busy_i (tx_busy),
        .uart_tx_data_o (tx_data),
        .uart_rx_en_o   (rx_en),
        .uart_rx_break_i(rx_break),
        .uart_rx_valid_i(rx_valid),
        .uart_rx_data_i (rx_data),
        .irq_o          (irq)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            busy_cnt <= 0;
        else if (tx_en)        busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    always @(posedge clk) begin
        if (rst_n && tx_en) tx_log.push_back(tx_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic [3:0] addr, input logic [31:0] wd, input logic we,
                          input logic re, input logic rxv, input logic [7:0] rxd,
                          output logic [31:0] rd);
        @(negedge clk);
        bus_if.sel       = 1'b1;
        bus_if.mem_addr  = {28'h0, addr};
        bus_if.mem_wdata = wd;
        bus_if.mem_we    = we;
        bus_if.mem_re    = re;
        rx_valid         = rxv;
        rx_data          = rxd;
        @(posedge clk);
        #1;
        rd = bus_if.mem_rdata;
        chk("mem_ready", {31'h0, bus_if.mem_ready}, 32'h1);
        @(negedge clk);
        bus_if.sel    = 1'b0;
        bus_if.mem_we = 1'b0;
        bus_if.mem_re = 1'b0;
        rx_valid      = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        access(addr, wd, 1'b1, 1'b0, 1'b0, 8'h00, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        access(addr, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00, v);
        chk(tag, v, exp);
    endtask

    task automatic rx_inject(input logic [7:0] d);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_tx [3];
        exp_tx = '{8'h41, 8'h42, 8'h43};
        bus_if.sel = 1'b0; bus_if.mem_addr = 32'h0; bus_if.mem_wdata = 32'h0;
        bus_if.mem_we = 1'b0; bus_if.mem_re = 1'b0;
        rx_break = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

        // Reset values
        #12;
        chk("rst_ready",   {31'h0, bus_if.mem_ready}, 32'h0);
        chk("rst_rdata",   bus_if.mem_rdata, 32'h0);
        chk("rst_tx_en",   {31'h0, tx_en}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_irq",     {31'h0, irq}, 32'h0);
        chk("rst_rx_en",   {31'h0, rx_en}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("status_reset", 4'h4, 32'h0000_0005);

        // Three bytes through the TX path
        wr(4'h0, 32'h41);
        @(posedge clk); #1;
        chk("ready_pulse_width", {31'h0, bus_if.mem_ready}, 32'h0);
        wr(4'h0, 32'h42);
        wr(4'h0, 32'h43);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_log.size() == 3 && !tx_busy) break;
        end
        repeat (5) @(negedge clk);
        chk("tx_count", tx_log.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("tx_byte", (i < tx_log.size()) ? {24'h0, tx_log[i]} : 32'hDEAD, {24'h0, exp_tx[i]});
        rd_chk("status_tx_done", 4'h4, 32'h0000_0005);

        // TX overflow with tx_en=0, W1C, flush
        wr(4'h8, 32'h2);
        for (int i = 0; i < 9; i++) wr(4'h0, 32'h60 + i);
        rd_chk("status_tx_full_ovf", 4'h4, 32'h0000_0816);
        chk("tx_no_pops", tx_log.size(), 32'd3);
        wr(4'h4, 32'h10);
        rd_chk("status_ovf_w1c", 4'h4, 32'h0000_0806);
        wr(4'h8, 32'h102);
        rd_chk("status_tx_flush", 4'h4, 32'h0000_0005);
        rd_chk("ctrl_flush_reads0", 4'h8, 32'h0000_0002);

        // RX path
        rx_inject(8'h55);
        rx_inject(8'hAA);
        rd_chk("status_rx2", 4'h4, 32'h0002_0001);
        rd_chk("rx_data_55", 4'h0, 32'h0000_0155);
        rd_chk("status_rx1", 4'h4, 32'h0001_0001);
        rd_chk("rx_data_aa", 4'h0, 32'h0000_01AA);
        rd_chk("rx_data_empty", 4'h0, 32'h0000_0000);
        rd_chk("status_rx0", 4'h4, 32'h0000_0005);

        // RX full: simultaneous push/pop, overrun, break, W1C priority
        for (int i = 0; i < 8; i++) rx_inject(8'h10 + 8'(i));
        rd_chk("status_rx_full", 4'h4, 32'h0008_0009);
        access(4'h0, 32'h0, 1'b0, 1'b1, 1'b1, 8'h99, r);
        chk("rx_pop_push_full", r, 32'h0000_0110);
        rd_chk("status_no_overrun", 4'h4, 32'h0008_0009);
        rx_inject(8'hEE);
        rd_chk("status_overrun", 4'h4, 32'h0008_0029);
        @(negedge clk); rx_break = 1'b1;
        @(negedge clk); rx_break = 1'b0;
        rd_chk("status_break", 4'h4, 32'h0008_0069);
        wr(4'h4, 32'h60);
        rd_chk("status_w1c_65", 4'h4, 32'h0008_0009);
        rd_chk("rx_data_11", 4'h0, 32'h0000_0111);
        rx_inject(8'h9A);
        access(4'h4, 32'h20, 1'b1, 1'b0, 1'b1, 8'hBB, r);
        rd_chk("status_set_beats_w1c", 4'h4, 32'h0008_0029);
        wr(4'h4, 32'h20);
        rd_chk("status_w1c_5", 4'h4, 32'h0008_0009);
        wr(4'h8, 32'h202);
        rd_chk("status_rx_flush", 4'h4, 32'h0000_0005);
        access(4'h0, 32'h0, 1'b0, 1'b1, 1'b1, 8'h77, r);
        chk("rx_pop_push_empty", r, 32'h0);
        rd_chk("status_push_landed", 4'h4, 32'h0001_0001);
        rd_chk("rx_data_77", 4'h0, 32'h0000_0177);

        // Reset in the middle of a byte with 3 bytes queued
        for (int i = 0; i < 4; i++) wr(4'h0, 32'hA0 + i);
        wr(4'h8, 32'h3);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (tx_busy) break;
        end
        rd_chk("status_mid_byte", 4'h4, 32'h0000_0384);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'h0, bus_if.mem_ready}, 32'h0);
        chk("mid_rst_tx_en", {31'h0, tx_en}, 32'h0);
        chk("mid_rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("mid_rst_rx_en", {31'h0, rx_en}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_chk("ctrl_after_rst", 4'h8, 32'h0000_0003);
        rd_chk("status_after_rst", 4'h4, 32'h0000_0005);

        // Unmapped offset and write/read collision
        wr(4'hC, 32'hFFFF_FFFF);
        rd_chk("reg_c_zero", 4'hC, 32'h0);
        access(4'h8, 32'h2, 1'b1, 1'b1, 1'b0, 8'h00, r);
        chk("we_re_rdata", r, 32'h0);
        rd_chk("we_re_write_won", 4'h8, 32'h0000_0002);

        // Interrupt enables
        wr(4'h8, 32'h1F);
        rd_chk("ctrl_irq_bits", 4'h8, IRQ_ON ? 32'h1F : 32'h3);
        wr(4'h8, 32'h7);
        repeat (2) @(negedge clk);
        chk("irq_idle", {31'h0, irq}, 32'h0);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'hC3;
        @(posedge clk); #1;
        chk("irq_lag", {31'h0, irq}, 32'h0);
        @(negedge clk);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        chk("irq_rx", {31'h0, irq}, {31'h0, IRQ_ON});
        rd_chk("rx_data_c3", 4'h0, 32'h0000_01C3);
        @(posedge clk); #1;
        chk("irq_cleared", {31'h0, irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
